wb_unit: RTL

//  Write-back stage: the writer side of the register-file write port read by the decode stage.

---
 rtl/wb_unit_pkg.sv | 15 +
 rtl/wb_unit_pipe_reg.sv | 65 ++++++
 rtl/wb_unit.sv | 118 +++++++++++
 3 files changed

// File: rtl/wb_unit_pkg.sv
// Shared definitions for the write-back stage: register indices, default widths
// and the FSM state encoding.
package wb_unit_pkg;

  localparam int DATA_W_DEF   = 32;
  localparam int REG_AW_DEF   = 5;
  localparam int SP_REG_DEF   = 29;
  localparam int ZERO_REG_DEF = 0;

  typedef enum logic {
    S_WB     = 1'b0,
    S_POP_SP = 1'b1
  } wb_state_e;

endpackage

// File: rtl/wb_unit_pipe_reg.sv
// MEM/WB pipeline register: captures the MEM-stage instruction when en_i is high,
// holds it otherwise, and clears asynchronously on an active-low reset.
module wb_pipe_reg
  import wb_unit_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_i,
  input  logic              valid_i,
  input  logic              reg_write_i,
  input  logic              mem_to_reg_i,
  input  logic              pop_i,
  input  logic              sp_upd_i,
  input  logic [REG_AW-1:0] dest_i,
  input  logic [DATA_W-1:0] alu_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic              reg_write_o,
  output logic              mem_to_reg_o,
  output logic              pop_o,
  output logic              sp_upd_o,
  output logic [REG_AW-1:0] dest_o,
  output logic [DATA_W-1:0] alu_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_q, reg_write_q, mem_to_reg_q, pop_q, sp_upd_q;
  logic [REG_AW-1:0] dest_q;
  logic [DATA_W-1:0] alu_q, data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q      <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      pop_q        <= 1'b0;
      sp_upd_q     <= 1'b0;
      dest_q       <= '0;
      alu_q        <= '0;
      data_q       <= '0;
    end else if (en_i) begin
      valid_q      <= valid_i;
      reg_write_q  <= reg_write_i;
      mem_to_reg_q <= mem_to_reg_i;
      pop_q        <= pop_i;
      sp_upd_q     <= sp_upd_i;
      dest_q       <= dest_i;
      alu_q        <= alu_i;
      data_q       <= data_i;
    end
  end

  assign valid_o      = valid_q;
  assign reg_write_o  = reg_write_q;
  assign mem_to_reg_o = mem_to_reg_q;
  assign pop_o        = pop_q;
  assign sp_upd_o     = sp_upd_q;
  assign dest_o       = dest_q;
  assign alu_o        = alu_q;
  assign data_o       = data_q;

endmodule

// File: rtl/wb_unit.sv
// Write-back stage: MEM/WB register, write-data select and the POP sequencer that
// splits a POP into an rd write followed by an SP write over a single write port.
module wb_unit
  import wb_unit_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int REG_AW   = REG_AW_DEF,
  parameter int SP_REG   = SP_REG_DEF,
  parameter int ZERO_REG = ZERO_REG_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_valid,
  input  logic              mem_reg_write,
  input  logic              mem_to_reg,
  input  logic              mem_pop,
  input  logic              mem_sp_upd,
  input  logic [REG_AW-1:0] mem_dest_reg,
  input  logic [DATA_W-1:0] mem_alu_result,
  input  logic [DATA_W-1:0] mem_data,
  output logic              RegWrite,
  output logic [REG_AW-1:0] RegWrite_Reg,
  output logic [DATA_W-1:0] RegWrite_Data,
  output logic              wb_stall
);

  localparam logic [REG_AW-1:0] SP_A   = REG_AW'(SP_REG);
  localparam logic [REG_AW-1:0] ZERO_A = REG_AW'(ZERO_REG);

  wb_state_e         state_q, state_d;
  logic              v_q, rw_q, m2r_q, pop_q, sp_q;
  logic [REG_AW-1:0] dest_q;
  logic [DATA_W-1:0] alu_q, data_q;
  logic              we_d, stall_d;
  logic [REG_AW-1:0] waddr_d;
  logic [DATA_W-1:0] wdata_d;

  wb_pipe_reg #(
    .DATA_W(DATA_W),
    .REG_AW(REG_AW)
  ) u_pipe (
    .clk         (clk),
    .rst_n       (rst),
    .en_i        (!stall_d),
    .valid_i     (mem_valid),
    .reg_write_i (mem_reg_write),
    .mem_to_reg_i(mem_to_reg),
    .pop_i       (mem_pop),
    .sp_upd_i    (mem_sp_upd),
    .dest_i      (mem_dest_reg),
    .alu_i       (mem_alu_result),
    .data_i      (mem_data),
    .valid_o     (v_q),
    .reg_write_o (rw_q),
    .mem_to_reg_o(m2r_q),
    .pop_o       (pop_q),
    .sp_upd_o    (sp_q),
    .dest_o      (dest_q),
    .alu_o       (alu_q),
    .data_o      (data_q)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_WB;
    else      state_q <= state_d;
  end

  // Decode priority is pop > sp_upd > reg_write; only a POP to an ordinary
  // register needs the second cycle, the held instruction enters when it ends.
  always_comb begin
    state_d = state_q;
    we_d    = 1'b0;
    waddr_d = '0;
    wdata_d = '0;
    stall_d = 1'b0;
    unique case (state_q)
      S_WB: begin
        if (v_q) begin
          if (pop_q) begin
            we_d = 1'b1;
            if (dest_q == ZERO_A) begin
              waddr_d = SP_A;
              wdata_d = alu_q;
            end else if (dest_q == SP_A) begin
              waddr_d = SP_A;
              wdata_d = data_q;
            end else begin
              waddr_d = dest_q;
              wdata_d = data_q;
              stall_d = 1'b1;
              state_d = S_POP_SP;
            end
          end else if (sp_q) begin
            we_d    = 1'b1;
            waddr_d = SP_A;
            wdata_d = alu_q;
          end else if (rw_q) begin
            we_d    = (dest_q != ZERO_A);
            waddr_d = dest_q;
            wdata_d = m2r_q ? data_q : alu_q;
          end
        end
      end
      S_POP_SP: begin
        we_d    = 1'b1;
        waddr_d = SP_A;
        wdata_d = alu_q;
        state_d = S_WB;
      end
    endcase
  end

  assign RegWrite      = we_d;
  assign RegWrite_Reg  = waddr_d;
  assign RegWrite_Data = wdata_d;
  assign wb_stall      = stall_d;

endmodule
